// File: rtl/scanner_pkg.sv
// Shared types and default constants for the scanner upload-link arbiter.
//   arb_state_t : arbiter state, encoding doubles as the hex-display code
//   scan_sel_t  : which scanner owns (or last owned) the link
package scanner_pkg;

    localparam int unsigned BUF_DEPTH   = 10;  // buffer capacity in units
    localparam int unsigned CNT_W       = 4;   // width of the buffer fill counts
    localparam int unsigned HI_THRESH   = 8;   // fill level that requests without flush
    localparam int unsigned WDOG_CYCLES = 8;   // drain stall limit (watchdog build only)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        S1 = 1'b0,
        S2 = 1'b1
    } scan_sel_t;

endpackage

// File: rtl/scanner_rr_pick.sv
// Round-robin pick between the two scanner requests (combinational).
// Ports:
//   req_s1, req_s2 : link requests
//   last           : scanner served most recently
//   valid          : at least one request present
//   sel            : chosen scanner; on a tie the one that was not served last
module scanner_rr_pick
    import scanner_pkg::*;
(
    input  logic      req_s1,
    input  logic      req_s2,
    input  scan_sel_t last,
    output logic      valid,
    output scan_sel_t sel
);

    always_comb begin
        valid = req_s1 | req_s2;
        sel   = S1;
        if (req_s1 && req_s2) begin
            sel = (last == S1) ? S2 : S1;
        end else if (req_s2) begin
            sel = S2;
        end
    end

endmodule

// File: rtl/scanner_link_arbiter.sv
// Shares the upload link between scanner 1 and scanner 2 and drains the granted
// buffer one unit at a time (pop, then one cycle for the scanner to update its count).
// Optional watchdog: define SCANNER_ARB_WDOG_EN to add WDOG_CYCLES and the wdog_trip output.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   count_s1/2, ready_s1/2 : scanner buffer fill and idle/standby flags
//   flush                  : request from any ready scanner holding data
//   grant_s1/2, pop_s1/2   : link ownership and one-unit decrement pulses
//   busy, arb_state        : activity flag and state code for the hex display
//   xfer_done              : pulse on entry to RELEASE after a complete drain
//   wdog_trip              : pulse when a drain stalls (watchdog build only)
module scanner_link_arbiter
    import scanner_pkg::*;
#(
    parameter int unsigned BUF_DEPTH   = scanner_pkg::BUF_DEPTH,
    parameter int unsigned CNT_W       = scanner_pkg::CNT_W,
    parameter int unsigned HI_THRESH   = scanner_pkg::HI_THRESH
`ifdef SCANNER_ARB_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = scanner_pkg::WDOG_CYCLES
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count_s1,
    input  logic [CNT_W-1:0] count_s2,
    input  logic             ready_s1,
    input  logic             ready_s2,
    input  logic             flush,
    output logic             grant_s1,
    output logic             grant_s2,
    output logic             pop_s1,
    output logic             pop_s2,
    output logic             busy,
    output logic [1:0]       arb_state,
    output logic             xfer_done
`ifdef SCANNER_ARB_WDOG_EN
    ,
    output logic             wdog_trip
`endif
);

    if (2 ** CNT_W <= BUF_DEPTH) begin : g_bad_cfg
        $error("CNT_W is too narrow to hold BUF_DEPTH");
    end

    localparam logic [CNT_W-1:0] HI_LVL = CNT_W'(HI_THRESH);

    arb_state_t       state_q, state_d;
    scan_sel_t        sel_q, sel_d, last_q, last_d, pick_sel;
    logic             pick_valid, req_s1, req_s2;
    logic             pop_phase_q, pop_phase_d;
    logic [CNT_W-1:0] snap_q, snap_d, cnt_sel;
    logic             rdy_sel, pop_d, xfer_d, hold_d;

    assign req_s1 = ready_s1 && (count_s1 >= HI_LVL || (flush && count_s1 != '0));
    assign req_s2 = ready_s2 && (count_s2 >= HI_LVL || (flush && count_s2 != '0));

    assign cnt_sel = (sel_q == S1) ? count_s1 : count_s2;
    assign rdy_sel = (sel_q == S1) ? ready_s1 : ready_s2;

    scanner_rr_pick u_pick (
        .req_s1 (req_s1),
        .req_s2 (req_s2),
        .last   (last_q),
        .valid  (pick_valid),
        .sel    (pick_sel)
    );

`ifdef SCANNER_ARB_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            wd_hit, trip_d;

    assign wd_hit = (wd_q == WD_W'(WDOG_CYCLES - 1));

    // Counts WAIT cycles; the POP cycle and any non-DRAIN cycle restart it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            wdog_trip <= 1'b0;
        end else begin
            wdog_trip <= trip_d;
            if (state_q == DRAIN && !pop_phase_q) begin
                wd_q <= wd_q + WD_W'(1);
            end else begin
                wd_q <= '0;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        pop_phase_d = pop_phase_q;
        snap_d      = snap_q;
        pop_d       = 1'b0;
        xfer_d      = 1'b0;
`ifdef SCANNER_ARB_WDOG_EN
        trip_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_sel;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d     = DRAIN;
                pop_phase_d = 1'b1;
                if (rdy_sel && cnt_sel != '0) begin
                    pop_d  = 1'b1;
                    snap_d = cnt_sel;
                end
            end
            DRAIN: begin
                if (!rdy_sel) begin
                    state_d = RELEASE;
                end else if (pop_phase_q) begin
                    pop_phase_d = 1'b0;
                end else if (cnt_sel == '0) begin
                    state_d = RELEASE;
                    xfer_d  = 1'b1;
                end else if (cnt_sel < snap_q) begin
                    // Scanner has taken the last pop; issue the next one.
                    pop_phase_d = 1'b1;
                    pop_d       = 1'b1;
                    snap_d      = cnt_sel;
`ifdef SCANNER_ARB_WDOG_EN
                end else if (wd_hit) begin
                    state_d = RELEASE;
                    trip_d  = 1'b1;
`endif
                end
                if (state_d == RELEASE) begin
                    last_d = sel_q;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        hold_d = (state_d == GRANT) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= S1;
            last_q      <= S2;
            pop_phase_q <= 1'b0;
            snap_q      <= '0;
            grant_s1    <= 1'b0;
            grant_s2    <= 1'b0;
            pop_s1      <= 1'b0;
            pop_s2      <= 1'b0;
            busy        <= 1'b0;
            xfer_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            pop_phase_q <= pop_phase_d;
            snap_q      <= snap_d;
            grant_s1    <= hold_d && (sel_d == S1);
            grant_s2    <= hold_d && (sel_d == S2);
            pop_s1      <= pop_d && (sel_d == S1);
            pop_s2      <= pop_d && (sel_d == S2);
            busy        <= (state_d != IDLE);
            xfer_done   <= xfer_d;
        end
    end

    assign arb_state = state_q;

endmodule

// File: tb/tb_scanner_link_arbiter.sv
// Self-checking bench for scanner_link_arbiter: reset-state vector table, hand-written
// drain/abort/reset/watchdog sequences, and randomized scenarios against a
// transaction-level round-robin model.
module tb_scanner_link_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count_s1 = '0, count_s2 = '0;
    logic       ready_s1 = 1'b0, ready_s2 = 1'b0, flush = 1'b0;
    logic       grant_s1, grant_s2, pop_s1, pop_s2, busy, xfer_done;
    logic [1:0] arb_state;
`ifdef SCANNER_ARB_WDOG_EN
    logic       wdog_trip;
`endif

    always #5 clk = ~clk;

    scanner_link_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .count_s1  (count_s1),
        .count_s2  (count_s2),
        .ready_s1  (ready_s1),
        .ready_s2  (ready_s2),
        .flush     (flush),
        .grant_s1  (grant_s1),
        .grant_s2  (grant_s2),
        .pop_s1    (pop_s1),
        .pop_s2    (pop_s2),
        .busy      (busy),
        .arb_state (arb_state),
        .xfer_done (xfer_done)
`ifdef SCANNER_ARB_WDOG_EN
        ,
        .wdog_trip (wdog_trip)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor / scanner-model state, advanced once per cycle by step().
    int cyc = 0;
    int pops1, pops2, xfers, trips;
    int last_pop1 = -1, last_pop2 = -1;
    int g1_fall = -1, g2_rise = -1;
    int grants[$];
    int pop1_cyc[$];
    bit pg1 = 1'b0, pg2 = 1'b0;
    bit hold = 1'b0;  // freeze counts: scanner ignores pops

    // Model outputs
    int exp_q[$];
    int exp_a, exp_b;
    int model_last;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic reset_stats();
        pops1 = 0; pops2 = 0; xfers = 0; trips = 0;
        g1_fall = -1; g2_rise = -1;
        grants.delete();
        pop1_cyc.delete();
    endtask

    // One clock: sample at the falling edge, check invariants, act as the scanners.
    task automatic step();
        @(negedge clk);
        cyc++;
        check("grant_exclusive", grant_s1 & grant_s2, 0);
        check("pop1_needs_grant", pop_s1 & ~grant_s1, 0);
        check("pop2_needs_grant", pop_s2 & ~grant_s2, 0);
        if (pop_s1) begin
            check("pop1_count_nonzero", count_s1 != 0, 1);
            if (last_pop1 >= 0) check("pop1_rate", (cyc - last_pop1) >= 2, 1);
            last_pop1 = cyc;
            pops1++;
            pop1_cyc.push_back(cyc);
            if (!hold && count_s1 != 0) count_s1 = count_s1 - 1;
        end
        if (pop_s2) begin
            check("pop2_count_nonzero", count_s2 != 0, 1);
            if (last_pop2 >= 0) check("pop2_rate", (cyc - last_pop2) >= 2, 1);
            last_pop2 = cyc;
            pops2++;
            if (!hold && count_s2 != 0) count_s2 = count_s2 - 1;
        end
        if (grant_s1 && !pg1) grants.push_back(1);
        if (!grant_s1 && pg1) g1_fall = cyc;
        if (grant_s2 && !pg2) begin
            grants.push_back(2);
            g2_rise = cyc;
        end
        if (xfer_done) xfers++;
`ifdef SCANNER_ARB_WDOG_EN
        if (wdog_trip) trips++;
`endif
        pg1 = grant_s1;
        pg2 = grant_s2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_in(input int c1, input int c2, input bit r1, input bit r2, input bit f);
        count_s1 = 4'(c1); count_s2 = 4'(c2);
        ready_s1 = r1; ready_s2 = r2; flush = f;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        run(2);
        reset = 1'b0;
        model_last = 2;
    endtask

    // Transaction model: serve requests round-robin, each grant drains to zero.
    function automatic void model(input int c1, input int c2, input bit r1, input bit r2,
                                  input bit f);
        int a = c1;
        int b = c2;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            bit q1 = r1 && (a >= 8 || (f && a != 0));
            bit q2 = r2 && (b >= 8 || (f && b != 0));
            int pick;
            if (!q1 && !q2) break;
            if (q1 && q2) pick = (model_last == 1) ? 2 : 1;
            else pick = q1 ? 1 : 2;
            exp_q.push_back(pick);
            if (pick == 1) a = 0; else b = 0;
            model_last = pick;
        end
        exp_a = a;
        exp_b = b;
    endfunction

    typedef struct {
        int c1; int c2; bit r1; bit r2; bit f;
        int exp_grant;  // 0 none, 1 s1, 2 s2 (fresh from reset: s1 wins ties)
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8, 0, 1, 1, 0, 1};
        vecs[1] = '{7, 7, 1, 1, 0, 0};
        vecs[2] = '{7, 3, 1, 1, 1, 1};
        vecs[3] = '{0, 3, 1, 1, 1, 2};
        vecs[4] = '{10, 9, 0, 1, 0, 2};
        vecs[5] = '{9, 12, 0, 1, 0, 2};
        vecs[6] = '{15, 0, 1, 0, 0, 1};
        vecs[7] = '{0, 0, 1, 1, 1, 0};
        vecs[8] = '{8, 8, 1, 1, 0, 1};
        vecs[9] = '{3, 9, 1, 1, 0, 2};

        // Reset state
        #1;
        check("rst_grant_s1", grant_s1, 0);
        check("rst_grant_s2", grant_s2, 0);
        check("rst_busy", busy, 0);
        check("rst_state", arb_state, 0);
        check("rst_pops", {pop_s1, pop_s2, xfer_done}, 0);

        // Table: first decision out of reset
        foreach (vecs[i]) begin
            do_reset();
            set_in(vecs[i].c1, vecs[i].c2, vecs[i].r1, vecs[i].r2, vecs[i].f);
            step();
            check("vec_grant_s1", grant_s1, vecs[i].exp_grant == 1);
            check("vec_grant_s2", grant_s2, vecs[i].exp_grant == 2);
            check("vec_state", arb_state, (vecs[i].exp_grant != 0) ? 1 : 0);
            check("vec_busy", busy, vecs[i].exp_grant != 0);
        end

        // A: single full drain of 8
        do_reset();
        reset_stats();
        set_in(8, 0, 1, 0, 0);
        step();
        check("a_state_grant", arb_state, 1);
        check("a_no_pop_in_grant", pop_s1, 0);
        step();
        check("a_state_drain", arb_state, 2);
        run(25);
        check("a_pops", pops1, 8);
        check("a_xfers", xfers, 1);
        check("a_grant_fell", grant_s1, 0);
        check("a_state_idle", arb_state, 0);
        check("a_count", count_s1, 0);
        for (int k = 1; k < pop1_cyc.size(); k++)
            check("a_pop_spacing", pop1_cyc[k] - pop1_cyc[k-1], 2);

        // B: both at 9, twice; s1 first each time, one IDLE cycle between grants
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            reset_stats();
            set_in(9, 9, 1, 1, 0);
            run(60);
            check("b_ngrants", grants.size(), 2);
            if (grants.size() == 2) begin
                check("b_first", grants[0], 1);
                check("b_second", grants[1], 2);
            end
            check("b_gap", g2_rise - g1_fall, 2);
            check("b_pops", pops1 * 100 + pops2, 909);
            check("b_xfers", xfers, 2);
        end

        // C: below threshold needs flush; dropping flush mid-drain changes nothing
        reset_stats();
        set_in(0, 3, 0, 1, 0);
        run(10);
        check("c_no_grant", grants.size(), 0);
        check("c_idle", busy, 0);
        flush = 1'b1;
        for (int k = 0; k < 10 && pops2 == 0; k++) step();
        check("c_first_pop", pops2, 1);
        flush = 1'b0;
        run(20);
        check("c_pops", pops2, 3);
        check("c_count", count_s2, 0);
        check("c_xfers", xfers, 1);

        // D: ready_s1 drops after two pops
        reset_stats();
        set_in(8, 0, 1, 0, 0);
        for (int k = 0; k < 20 && pops1 < 2; k++) step();
        check("d_two_pops", pops1, 2);
        ready_s1 = 1'b0;
        step();
        check("d_release", arb_state, 3);
        check("d_no_xfer", xfer_done, 0);
        run(10);
        check("d_pops_total", pops1, 2);
        check("d_count_left", count_s1, 6);
        check("d_xfers", xfers, 0);
        check("d_idle", busy, 0);

        // E: reset in the middle of a drain
        reset_stats();
        set_in(8, 0, 1, 0, 0);
        for (int k = 0; k < 20 && pops1 < 1; k++) step();
        step();
        check("e_in_drain", arb_state, 2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("e_grant_async", grant_s1, 0);
        check("e_pop_async", pop_s1, 0);
        check("e_busy_async", busy, 0);
        check("e_state_async", arb_state, 0);
        run(2);
        reset_stats();
        set_in(8, 8, 1, 1, 0);
        reset = 1'b0;
        step();
        check("e_s1_wins", grant_s1, 1);
        check("e_s2_waits", grant_s2, 0);
        run(60);
        check("e_ngrants", grants.size(), 2);
        if (grants.size() == 2) check("e_order", grants[0] * 10 + grants[1], 12);

        // Stalled scanner: count never moves after a pop
        reset_stats();
        hold = 1'b1;
        set_in(8, 0, 1, 0, 0);
`ifdef SCANNER_ARB_WDOG_EN
        for (int k = 0; k < 30 && trips == 0; k++) step();
        check("w_trip", trips, 1);
        ready_s1 = 1'b0;
        run(5);
        check("w_released", busy, 0);
        check("w_grant", grant_s1, 0);
        check("w_no_xfer", xfers, 0);
        check("w_pops", pops1, 1);
`else
        run(30);
        check("w_still_drain", arb_state, 2);
        check("w_grant_held", grant_s1, 1);
        check("w_pops", pops1, 1);
        ready_s1 = 1'b0;
        run(5);
        check("w_abort_idle", busy, 0);
`endif
        hold = 1'b0;
        set_in(0, 0, 0, 0, 0);

        // Randomized scenarios against the transaction model
        do_reset();
        for (int s = 0; s < 40; s++) begin
            int c1 = $urandom_range(0, 15);
            int c2 = $urandom_range(0, 15);
            bit r1 = 1'($urandom_range(0, 3) != 0);
            bit r2 = 1'($urandom_range(0, 3) != 0);
            bit f  = 1'($urandom_range(0, 2) == 0);
            reset_stats();
            model(c1, c2, r1, r2, f);
            set_in(c1, c2, r1, r2, f);
            run(75);
            check("rnd_ngrants", grants.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < grants.size(); k++)
                check("rnd_grant_order", grants[k], exp_q[k]);
            check("rnd_count_s1", count_s1, exp_a);
            check("rnd_count_s2", count_s2, exp_b);
            check("rnd_pops_s1", pops1, c1 - exp_a);
            check("rnd_pops_s2", pops2, c2 - exp_b);
            check("rnd_xfers", xfers, exp_q.size());
            check("rnd_idle", busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
